fifo_uart_tx: RTL and testbench

Drain stage on the read side of the FIFO. When enabled and the FIFO is non-empty, it pops one `width`-bit word, splits it into bytes (most significant byte first), and transmits each byte as an 8N1 UART frame on `tx`. It runs on the FIFO's clock and reset, and it is the only block that drives the FIFO read enable.

---
 rtl/fifo_uart_tx_pkg.sv | 20 ++
 rtl/fifo_uart_tx_baud_gen.sv | 45 ++++
 rtl/fifo_uart_tx.sv | 153 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART drain stage: state encodings,
// serial line levels and frame geometry.
package fifo_uart_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_START = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_STOP  = 3'd5;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Baud-period counter: counts 0..clk_div-1 and flags the last cycle of
// each bit period. A synchronous clear parks it at zero so every timed
// state starts a fresh period.
module fifo_uart_tx_baud_gen #(
    parameter int clk_div   = 868,
    parameter int cnt_width = $clog2(clk_div)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [cnt_width-1:0] TERM_CNT = cnt_width'(clk_div - 1);

    if (clk_div < 2) begin : g_chk_div
        $error("fifo_uart_tx_baud_gen: clk_div must be at least 2");
    end
    if (cnt_width < $clog2(clk_div)) begin : g_chk_cnt
        $error("fifo_uart_tx_baud_gen: cnt_width too narrow for clk_div");
    end

    logic [cnt_width-1:0] cnt_q;
    logic [cnt_width-1:0] cnt_d;

    assign tick = !clr && (cnt_q == TERM_CNT);

    // Next count: wrap at terminal count, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side drain: pops one word at a time and sends it MSB byte
// first as 8N1 UART frames.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | line high, waiting for en and a non-empty FIFO
//   FETCH | one-cycle fifo_re pulse
//   LOAD  | capture fifo_data, select the most significant byte
//   START | start bit, one baud period
//   DATA  | 8 data bits LSB first, one baud period each
//   STOP  | stop bit; next byte, next word, or back to IDLE
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int width     = 16,
    parameter int clk_div   = 868,
    parameter int cnt_width = $clog2(clk_div)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data,
    output logic             fifo_re,
    output logic             tx,
    output logic             busy
);

    localparam int NBYTES = width / DATA_BITS;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    if ((width % DATA_BITS) != 0 || width < DATA_BITS) begin : g_chk_width
        $error("fifo_uart_tx: width must be a non-zero multiple of 8");
    end
    if (clk_div < 2) begin : g_chk_div
        $error("fifo_uart_tx: clk_div must be at least 2");
    end

    state_t              state_q, state_d;
    logic [width-1:0]    word_q, word_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] cur_byte;
    logic                baud_clr;
    logic                tick;

    // The word register is shifted left after each byte, so the byte on
    // the wire is always the top slice.
    assign cur_byte = word_q[width-1 -: DATA_BITS];

    // Untimed states hold the baud counter at zero so START begins a full
    // period; timed states rely on the wrap at terminal count.
    assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_FETCH) ||
                      (state_q == ST_LOAD);

    fifo_uart_tx_baud_gen #(
        .clk_div   (clk_div),
        .cnt_width (cnt_width)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                word_d     = fifo_data;
                byte_idx_d = '0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        word_d     = word_q << DATA_BITS;
                        state_d    = ST_START;
                    end else if (en && !fifo_empty) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    // Line level decoded from registered state only.
    always_comb begin
        tx = TX_IDLE;
        case (state_q)
            ST_START: tx = START_BIT;
            ST_DATA:  tx = cur_byte[bit_idx_q];
            ST_STOP:  tx = STOP_BIT;
            default:  tx = TX_IDLE;
        endcase
    end

    // FETCH is only entered after seeing a non-empty FIFO, so the pulse
    // never lands on an empty FIFO.
    assign fifo_re = (state_q == ST_FETCH);
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with clk_div=4, width=16.
// A FIFO model feeds the DUT; a line monitor decodes 8N1 frames with
// exact per-cycle bit timing and compares bytes against a scoreboard.
module tb_fifo_uart_tx;

    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 10 * CLK_DIV;
    localparam int WORD_BUSY = 2 + (WIDTH / 8) * FRAME;   // FETCH + LOAD + frames = 82

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_data  = '0;
    logic             fifo_re;
    logic             tx;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]       exp_q[$];
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] push_w = '0;
    int               push_cnt  = 0;
    int               push_seen = 0;

    int re_count = 0;
    int re_cyc[$];

    fifo_uart_tx #(
        .width   (WIDTH),
        .clk_div (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w, input bit exp_en);
        push_w = w;
        if (exp_en) begin
            for (int i = WIDTH / 8 - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
        end
        push_cnt++;
        step();
    endtask

    task automatic wait_busy_run(input int budget, output int len);
        int t;
        t = 0;
        len = 0;
        while (busy !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b1) begin
            len = -1;
            return;
        end
        while (busy === 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
            len++;
        end
        if (busy === 1'b1) len = -1;
    endtask

    task automatic wait_tx_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
        end
    endtask

    // Synchronous FIFO model: read data appears the cycle after fifo_re.
    always @(posedge clk) begin
        if (fifo_re && fq.size() != 0) fifo_data <= fq.pop_front();
        if (push_cnt != push_seen) begin
            fq.push_back(push_w);
            push_seen <= push_cnt;
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Read-enable monitor: pulse width, no read while empty, pulse times.
    initial begin : re_mon
        int   cyc;
        logic prev_re;
        cyc = 0;
        prev_re = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_re === 1'b1) begin
                re_count++;
                re_cyc.push_back(cyc);
                check("re_single_cycle", 32'(prev_re), 32'd0);
                check("re_while_empty", 32'(fifo_empty), 32'd0);
            end
            prev_re = fifo_re;
        end
    end

    // Line monitor: decode frames, checking every sample of every bit.
    initial begin : frame_mon
        logic       s[FRAME];
        logic [7:0] b;
        bit         aborted;
        bit         fmt_ok;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                s[0] = 1'b0;
                aborted = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[k] = tx;
                end
                if (!aborted) begin
                    fmt_ok = 1'b1;
                    for (int bi = 0; bi < 10; bi++)
                        for (int j = 1; j < CLK_DIV; j++)
                            if (s[bi*CLK_DIV+j] !== s[bi*CLK_DIV]) fmt_ok = 1'b0;
                    if (s[9*CLK_DIV] !== 1'b1) fmt_ok = 1'b0;
                    for (int i = 0; i < 8; i++) b[i] = s[CLK_DIV*(i+1)];
                    check("frame_format", 32'(fmt_ok), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got byte %0h, required no frame", b);
                    end else begin
                        check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int len;
        int base;
        int n;
        int lows;
        bit ok;

        rst = 1'b0;
        en  = 1'b1;

        // Reset held with a word waiting and en high.
        push_word(16'hA55A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_tx", 32'(tx), 32'd1);
            check("reset_fifo_re", 32'(fifo_re), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
        end

        // Single word 0xA55A: bytes A5, 5A.
        step();
        base = re_count;
        rst = 1'b1;
        wait_busy_run(300, len);
        check("single_busy_len", 32'(len), 32'(WORD_BUSY));
        check("single_re_count", 32'(re_count - base), 32'd1);
        check("single_idle_tx", 32'(tx), 32'd1);

        // Back-to-back words: bytes 00,01,80,00,FF,FF; one pop every 82 cycles.
        step();
        base = re_count;
        n = re_cyc.size();
        push_word(16'h0001, 1'b1);
        push_word(16'h8000, 1'b1);
        push_word(16'hFFFF, 1'b1);
        wait_busy_run(800, len);
        check("b2b_busy_len", 32'(len), 32'(3 * WORD_BUSY));
        check("b2b_re_count", 32'(re_count - base), 32'd3);
        if (re_cyc.size() >= n + 3) begin
            check("b2b_gap_1", 32'(re_cyc[n+1] - re_cyc[n]), 32'd82);
            check("b2b_gap_2", 32'(re_cyc[n+2] - re_cyc[n+1]), 32'd82);
        end

        // Empty FIFO with en high: nothing happens for 100 cycles.
        step();
        base = re_count;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("empty_re_count", 32'(re_count - base), 32'd0);
        check("empty_tx_low", 32'(lows), 32'd0);

        // Enable drop during byte 0 of 0x1234 with 0x5678 queued behind it.
        step();
        base = re_count;
        push_word(16'h1234, 1'b1);
        push_word(16'h5678, 1'b0);
        repeat (10) step();
        en = 1'b0;
        wait_busy_run(300, len);
        check("endrop_finished", 32'(len > 0), 32'd1);
        repeat (20) step();
        check("endrop_re_count", 32'(re_count - base), 32'd1);
        check("endrop_busy", 32'(busy), 32'd0);
        check("endrop_tx", 32'(tx), 32'd1);

        // Mid-frame reset: 0x5678 is popped then aborted; 0xBEEF follows.
        push_word(16'hBEEF, 1'b1);
        base = re_count;
        en = 1'b1;
        wait_tx_low(50, ok);
        check("midrst_start_seen", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        check("midrst_data_bit0", 32'(tx), 32'd0);
        step();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b1;
        wait_busy_run(300, len);
        check("midrst_next_busy_len", 32'(len), 32'(WORD_BUSY));
        check("midrst_re_count", 32'(re_count - base), 32'd2);

        repeat (10) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("final_tx", 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
